multi_approach_signal_ctrl: RTL and testbench
=============================================

// Module: multi_approach_signal_ctrl
// PURPOSE
//   N-approach traffic signal controller; successor to the fixed 2-approach light.
//   Serves approaches 0..N-1 round-robin: GREEN -> YELLOW -> ALL_RED.
//   Green, yellow and all-red durations are runtime-programmable.
//   Adds latched pedestrian walk requests and a safe flashing-red mode.
//   Sits directly under the board top level and drives the LED lamp outputs.
// PARAMETERS
//   NUM_APPR  2           number of approaches (2..8)
//   CLK_DIV   50000000    CLOCK cycles per 1 s tick (>=2; bench uses 4)
//   TIMER_W   8           width of duration inputs / down-counter (seconds)
// PORTS
//   CLOCK        in   1          system clock
//   RESET        in   1          asynchronous, active-high reset
//   green_time   in   TIMER_W    green duration, s
//   yellow_time  in   TIMER_W    yellow duration, s
//   allred_time  in   TIMER_W    all-red clearance duration, s
//   ped_req      in   NUM_APPR   pedestrian button per approach, level or pulse
//   flash_mode   in   1          1 = request flashing-red mode
//   lamp_g       out  NUM_APPR   green lamp per approach
//   lamp_y       out  NUM_APPR   yellow lamp per approach
//   lamp_r       out  NUM_APPR   red lamp per approach
//   walk         out  NUM_APPR   pedestrian walk lamp per approach
//   active_appr  out  $clog2(NUM_APPR)  approach currently green/yellow
// BEHAVIOUR
//   Reset (async, any time): lamp_r = all 1; lamp_g/lamp_y/walk = 0.
//     active_appr = 0; ped latches cleared; prescaler cleared.
//     State = ALL_RED with timer = allred_time.
//     The first green after release goes to approach 0.
//   Tick: one-cycle pulse every CLK_DIV cycles. Counter restarts on reset. All timing is in ticks.
//   States: ALL_RED, GREEN, YELLOW, FLASH.
//   Timer is loaded on state entry from the matching *_time input.
//     A duration of 0 is treated as 1. Inputs are sampled only at entry.
//   Timer decrements on each tick. When it is 1 and a tick occurs, the state advances next cycle.
//     A state therefore lasts exactly N ticks (N = loaded value).
//   ALL_RED end: if flash_mode -> FLASH.
//     Otherwise -> GREEN and active_appr = next approach (wraps NUM_APPR-1 -> 0).
//     Exception: the first entry after reset or after FLASH selects approach 0.
//   GREEN end -> YELLOW. YELLOW end -> ALL_RED.
//   flash_mode in GREEN truncates green: -> YELLOW on the next tick.
//     Yellow and all-red are never shortened.
//   FLASH: g = y = walk = 0. All lamp_r toggle on each tick, starting at 1.
//     When flash_mode = 0 seen on a tick -> ALL_RED (lamp_r all 1), then approach 0.
//   Lamps are registered outputs driven directly from state.
//     active approach: GREEN -> g = 1; YELLOW -> y = 1; r = 0.
//     All other approaches: r = 1.
//   Invariant: at most one bit of (lamp_g | lamp_y) is set. Never g and y on the same approach.
//   Ped: ped_req[i] sets sticky latch[i] on any cycle.
//     On GREEN entry for approach i, latch[i] is cleared and walk[i] = 1 for the whole green.
//     walk[i] drops on YELLOW entry.
//     A request for approach i arriving during its own green sets the latch for its next green.
//     It is never served mid-green.
//   Simultaneous latch set and clear in the same cycle: the set wins, so the request is kept.
//   Latches are held, not served, in FLASH.
// STRUCTURE
//   Shared package signal_pkg:
//     state enum (ALL_RED, GREEN, YELLOW, FLASH)
//     MIN_DURATION = 1
//   Sub-module tick_prescaler #(CLK_DIV): CLOCK, RESET -> tick.
//     Reusable by other timed blocks.
//   Rest in one module: FSM, timer, ped latches, lamp decode.
// TESTING  (NUM_APPR=3, CLK_DIV=4, green=5, yellow=3, allred=1)
//   Reset release ->
//     1 tick all red, then g[0]=1 for 20 cycles, y[0]=1 for 12, all red for 4, then g[1]=1.
//   Free-run 3 full cycles ->
//     green order 0,1,2,0; wrap from 2 to 0.
//     Assert one-hot (g|y) and r = ~(g|y) every cycle.
//   ped_req[2] 1-cycle pulse during g[0] ->
//     walk[2]=1 for exactly approach 2 green.
//     walk[0] and walk[1] stay 0.
//     A second pulse during g[2] -> walk[2] again on the following approach-2 green.
//   flash_mode=1 at 2nd tick of g[1] ->
//     y[1] next tick for 3 ticks, all red 1 tick, then lamp_r toggles each tick.
//     flash_mode=0 -> all red 1 tick, then g[0].
//   green_time=0 -> green lasts 1 tick.
//     green_time changed mid-green -> current green keeps its old length, next green uses the new one.
//   RESET asserted mid-yellow ->
//     same cycle: lamp_r = 111, g = y = walk = 0, ped latches cleared.
//     Reset-release sequence then repeats from approach 0.

Source files
------------

// File: rtl/signal_pkg.sv
// Shared types and constants for the signal controller family.
package signal_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2,
        FLASH   = 2'd3
    } state_t;

    // Shortest phase in ticks; a programmed duration of 0 is promoted to this.
    localparam int MIN_DURATION = 1;

endpackage

// File: rtl/tick_prescaler.sv
// Divides CLOCK down to a one-cycle tick pulse every CLK_DIV cycles.
module tick_prescaler #(
    parameter int CLK_DIV = 50000000
) (
    input  logic CLOCK,
    input  logic RESET,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(CLK_DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_W'(CLK_DIV - 1));

endmodule

// File: rtl/multi_approach_signal_ctrl.sv
// N-approach round-robin signal controller with pedestrian latches and
// flashing-red mode; lamps are registered straight from the next-state decode.
module multi_approach_signal_ctrl
    import signal_pkg::*;
#(
    parameter  int NUM_APPR = 2,
    parameter  int CLK_DIV  = 50000000,
    parameter  int TIMER_W  = 8,
    localparam int APPR_W   = (NUM_APPR > 1) ? $clog2(NUM_APPR) : 1
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic [TIMER_W-1:0]  green_time,
    input  logic [TIMER_W-1:0]  yellow_time,
    input  logic [TIMER_W-1:0]  allred_time,
    input  logic [NUM_APPR-1:0] ped_req,
    input  logic                flash_mode,
    output logic [NUM_APPR-1:0] lamp_g,
    output logic [NUM_APPR-1:0] lamp_y,
    output logic [NUM_APPR-1:0] lamp_r,
    output logic [NUM_APPR-1:0] walk,
    output logic [APPR_W-1:0]   active_appr
);

    logic tick;

    tick_prescaler #(.CLK_DIV(CLK_DIV)) u_tick (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .tick  (tick)
    );

    state_t              state, state_nxt;
    logic [TIMER_W-1:0]  timer, timer_nxt;
    logic [APPR_W-1:0]   appr_nxt, appr_succ;
    logic                first, first_nxt;
    logic [NUM_APPR-1:0] ped_latch, ped_latch_nxt, ped_clr, appr_mask;
    logic [NUM_APPR-1:0] g_nxt, y_nxt, r_nxt, walk_nxt;

    function automatic logic [TIMER_W-1:0] load_dur(input logic [TIMER_W-1:0] t);
        return (t < TIMER_W'(MIN_DURATION)) ? TIMER_W'(MIN_DURATION) : t;
    endfunction

    assign appr_succ = (active_appr == APPR_W'(NUM_APPR - 1)) ? '0 : active_appr + APPR_W'(1);

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path infers a latch.
        state_nxt = state;
        timer_nxt = timer;
        appr_nxt  = active_appr;
        first_nxt = first;
        g_nxt     = lamp_g;
        y_nxt     = lamp_y;
        r_nxt     = lamp_r;
        walk_nxt  = walk;
        appr_mask = '0;
        ped_clr   = '0;

        if (timer == '0) begin
            // Zero only right after reset: the opening all-red loads its duration here.
            timer_nxt = load_dur(allred_time);
        end else if (tick) begin
            timer_nxt = timer - TIMER_W'(1);
            unique case (state)
                ALL_RED: begin
                    if (timer == TIMER_W'(1)) begin
                        if (flash_mode) begin
                            state_nxt = FLASH;
                            timer_nxt = TIMER_W'(MIN_DURATION);
                            r_nxt     = '1;
                        end else begin
                            state_nxt = GREEN;
                            timer_nxt = load_dur(green_time);
                            appr_nxt  = first ? '0 : appr_succ;
                            first_nxt = 1'b0;
                            appr_mask = NUM_APPR'(1) << appr_nxt;
                            g_nxt     = appr_mask;
                            y_nxt     = '0;
                            r_nxt     = ~appr_mask;
                            walk_nxt  = ped_latch & appr_mask;
                            ped_clr   = appr_mask;
                        end
                    end
                end
                GREEN: begin
                    if (timer == TIMER_W'(1) || flash_mode) begin
                        state_nxt = YELLOW;
                        timer_nxt = load_dur(yellow_time);
                        y_nxt     = lamp_g;
                        g_nxt     = '0;
                        walk_nxt  = '0;
                    end
                end
                YELLOW: begin
                    if (timer == TIMER_W'(1)) begin
                        state_nxt = ALL_RED;
                        timer_nxt = load_dur(allred_time);
                        y_nxt     = '0;
                        r_nxt     = '1;
                    end
                end
                FLASH: begin
                    timer_nxt = timer;
                    if (!flash_mode) begin
                        state_nxt = ALL_RED;
                        timer_nxt = load_dur(allred_time);
                        r_nxt     = '1;
                        first_nxt = 1'b1;
                    end else begin
                        r_nxt = ~lamp_r;
                    end
                end
            endcase
        end

        // A request landing on the serving cycle survives for the next green.
        ped_latch_nxt = (ped_latch & ~ped_clr) | ped_req;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state       <= ALL_RED;
            timer       <= '0;
            active_appr <= '0;
            first       <= 1'b1;
            ped_latch   <= '0;
            lamp_g      <= '0;
            lamp_y      <= '0;
            lamp_r      <= '1;
            walk        <= '0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            active_appr <= appr_nxt;
            first       <= first_nxt;
            ped_latch   <= ped_latch_nxt;
            lamp_g      <= g_nxt;
            lamp_y      <= y_nxt;
            lamp_r      <= r_nxt;
            walk        <= walk_nxt;
        end
    end

endmodule

// File: tb/tb_multi_approach_signal_ctrl.sv
// Scoreboard bench: expected lamp segments (pattern + length in cycles) are
// queued as stimulus is applied and compared as each output segment ends.
module tb_multi_approach_signal_ctrl;

    localparam int NA = 3;
    localparam int CD = 4;
    localparam int TW = 8;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b1;
    logic [TW-1:0] green_time  = 8'd5;
    logic [TW-1:0] yellow_time = 8'd3;
    logic [TW-1:0] allred_time = 8'd1;
    logic [NA-1:0] ped_req     = '0;
    logic          flash_mode  = 1'b0;
    logic [NA-1:0] lamp_g, lamp_y, lamp_r, walk;
    logic [1:0]    active_appr;

    multi_approach_signal_ctrl #(.NUM_APPR(NA), .CLK_DIV(CD), .TIMER_W(TW)) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .green_time  (green_time),
        .yellow_time (yellow_time),
        .allred_time (allred_time),
        .ped_req     (ped_req),
        .flash_mode  (flash_mode),
        .lamp_g      (lamp_g),
        .lamp_y      (lamp_y),
        .lamp_r      (lamp_r),
        .walk        (walk),
        .active_appr (active_appr)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Segment pattern is {g, y, r, walk}; len < 0 means length not checked.
    typedef struct {
        logic [11:0] pat;
        int          len;
    } seg_t;

    seg_t exp_q[$];
    int   seg_idx = 0;

    localparam logic [11:0] P_AR = {3'b000, 3'b000, 3'b111, 3'b000};
    localparam logic [11:0] P_F0 = 12'h000;

    function automatic logic [2:0] bit_of(input int i);
        logic [2:0] m;
        m    = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [11:0] p_g(input int i, input logic [2:0] w);
        return {bit_of(i), 3'b000, ~bit_of(i), w};
    endfunction

    function automatic logic [11:0] p_y(input int i);
        return {3'b000, bit_of(i), ~bit_of(i), 3'b000};
    endfunction

    function automatic void push_seg(input logic [11:0] pat, input int len);
        seg_t s;
        s.pat = pat;
        s.len = len;
        exp_q.push_back(s);
    endfunction

    function automatic int idx_of(input logic [2:0] v);
        for (int i = 0; i < NA; i++) if (v[i]) return i;
        return 0;
    endfunction

    // ---------------- monitor ----------------
    logic [11:0] seg_pat;
    int          seg_len  = 0;
    bit          seg_open = 1'b0;

    task automatic close_seg(input bit aborted);
        seg_t e;
        if (exp_q.size() == 0) begin
            check($sformatf("seg%0d_unexpected", seg_idx), {20'b0, seg_pat}, 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("seg%0d_pattern", seg_idx), {20'b0, seg_pat}, {20'b0, e.pat});
            if (!aborted && e.len >= 0)
                check($sformatf("seg%0d_cycles", seg_idx), seg_len, e.len);
        end
        seg_idx++;
    endtask

    always @(negedge CLOCK) begin
        logic [2:0]  gy, not_gy;
        logic [11:0] cur;
        if (RESET) begin
            if (seg_open) close_seg(1'b1);
            seg_open = 1'b0;
        end else begin
            gy     = lamp_g | lamp_y;
            not_gy = ~gy;
            check("gy_onehot", {31'b0, $onehot0(gy)}, 32'd1);
            check("g_and_y", {29'b0, lamp_g & lamp_y}, 32'd0);
            if (gy != 3'b000) begin
                check("r_complement", {29'b0, lamp_r}, {29'b0, not_gy});
                check("active_appr", {30'b0, active_appr}, idx_of(gy));
            end
            cur = {lamp_g, lamp_y, lamp_r, walk};
            if (!seg_open) begin
                seg_open = 1'b1;
                seg_pat  = cur;
                seg_len  = 1;
            end else if (cur == seg_pat) begin
                seg_len++;
            end else begin
                close_seg(1'b0);
                seg_pat = cur;
                seg_len = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic sel(input int kind, input int idx);
        case (kind)
            0:       return lamp_g[idx];
            1:       return lamp_y[idx];
            default: return (lamp_r == 3'b000);
        endcase
    endfunction

    task automatic wait_rise(input string tag, input int kind, input int idx);
        logic prev, now;
        prev = sel(kind, idx);
        for (int n = 0; n < 600; n++) begin
            @(negedge CLOCK);
            now = sel(kind, idx);
            if (!prev && now) return;
            prev = now;
        end
        check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pulse_ped(input logic [2:0] v);
        @(posedge CLOCK); #1 ped_req = v;
        @(posedge CLOCK); #1 ped_req = '0;
    endtask

    initial begin
        // Opening sequence: greens 0,1,2(walk),0,1,2(walk),0 then the flash green.
        push_seg(P_AR, 4);
        for (int k = 0; k < 6; k++) begin
            push_seg(p_g(k % 3, (k % 3 == 2) ? 3'b100 : 3'b000), 20);
            push_seg(p_y(k % 3), 12);
            push_seg(P_AR, 4);
        end
        push_seg(p_g(0, 3'b000), 20);
        push_seg(p_y(0), 12);
        push_seg(P_AR, 4);

        repeat (3) @(posedge CLOCK);
        #1;
        check("reset_lamp_r", {29'b0, lamp_r}, 32'd7);
        check("reset_lamp_g", {29'b0, lamp_g}, 32'd0);
        check("reset_walk", {29'b0, walk}, 32'd0);
        check("reset_appr", {30'b0, active_appr}, 32'd0);
        RESET = 1'b0;

        wait_rise("g0_first", 0, 0);
        pulse_ped(3'b100);
        wait_rise("g2_first", 0, 2);
        pulse_ped(3'b100);
        wait_rise("g2_second", 0, 2);

        wait_rise("g1_flash", 0, 1);
        push_seg(p_g(1, 3'b000), 12);
        push_seg(p_y(1), 12);
        push_seg(P_AR, 8);
        push_seg(P_F0, 4);
        push_seg(P_AR, 4);
        push_seg(P_F0, 4);
        push_seg(P_AR, 4);
        repeat (8) @(posedge CLOCK);
        #1 flash_mode = 1'b1;

        wait_rise("flash_dark", 2, 0);
        repeat (8) @(posedge CLOCK);
        #1 flash_mode = 1'b0;
        push_seg(p_g(0, 3'b000), 20);
        push_seg(p_y(0), 12);
        push_seg(P_AR, 4);
        push_seg(p_g(1, 3'b000), 4);
        push_seg(p_y(1), 12);
        push_seg(P_AR, 4);
        push_seg(p_g(2, 3'b000), 20);
        push_seg(p_y(2), -1);

        wait_rise("g0_after_flash", 0, 0);
        repeat (6) @(posedge CLOCK);
        #1 green_time = 8'd0;
        wait_rise("g1_short", 0, 1);
        @(posedge CLOCK);
        #1 green_time = 8'd5;

        wait_rise("g2_last", 0, 2);
        pulse_ped(3'b010);
        wait_rise("y2_last", 1, 2);
        push_seg(P_AR, 4);
        push_seg(p_g(0, 3'b000), 20);
        push_seg(p_y(0), 12);
        push_seg(P_AR, 4);
        push_seg(p_g(1, 3'b000), 20);
        repeat (5) @(posedge CLOCK);
        #1 RESET = 1'b1;
        #1;
        check("midyellow_reset_r", {29'b0, lamp_r}, 32'd7);
        check("midyellow_reset_g", {29'b0, lamp_g}, 32'd0);
        check("midyellow_reset_y", {29'b0, lamp_y}, 32'd0);
        check("midyellow_reset_walk", {29'b0, walk}, 32'd0);
        check("midyellow_reset_appr", {30'b0, active_appr}, 32'd0);
        repeat (3) @(posedge CLOCK);
        #1 RESET = 1'b0;

        for (int n = 0; n < 600; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge CLOCK);
        end
        check("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        check("watchdog", 32'd0, 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
